// File: rtl/memory_access.sv
// MIPS-32 MEM stage: data memory with wait-state handshake, branch resolution,
// and the MEM/WB pipeline register.
module memory_access #(
    parameter int MEM_WORDS   = 256,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  M,
    input  logic [2:0]  WB,
    input  logic [31:0] Alu_result,
    input  logic [31:0] Add_result,
    input  logic        Zero,
    input  logic [31:0] Dato2_M,
    input  logic [4:0]  Direccion,
    input  logic [31:0] jump_address,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] Branch_target,
    output logic [2:0]  WB_out,
    output logic [31:0] Read_data_out,
    output logic [31:0] Alu_result_out,
    output logic [4:0]  Direccion_out,
    output logic [31:0] jump_address_out
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 mem_op;
    logic                 capture;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] word_idx;

    logic [31:0] mem [MEM_WORDS];

    logic [2:0]  wb_q;
    logic [31:0] rdata_q;
    logic [31:0] alu_q;
    logic [4:0]  dir_q;
    logic [31:0] jump_q;

    assign mem_op   = M[1] | M[0];
    assign word_idx = Alu_result[ADDR_BITS+1:2];

    // capture marks the edge on which MEM/WB takes the inputs instead of a bubble
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!mem_op || WAIT_CYCLES == 0) begin
                    capture = 1'b1;
                end else begin
                    stall   = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign PCSrc         = M[2] & Zero & ~stall;
    assign Branch_target = Add_result;

    // A store interrupted by reset never reaches memory
    assign mem_we = capture & M[0] & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx] <= Dato2_M;
        end
    end

    // Read sees the pre-write word, so a combined read/write returns old data
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            dir_q   <= '0;
            jump_q  <= '0;
        end else if (capture) begin
            wb_q    <= WB;
            rdata_q <= M[1] ? mem[word_idx] : 32'd0;
            alu_q   <= Alu_result;
            dir_q   <= Direccion;
            jump_q  <= jump_address;
        end else begin
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            dir_q   <= '0;
            jump_q  <= '0;
        end
    end

    assign WB_out           = wb_q;
    assign Read_data_out    = rdata_q;
    assign Alu_result_out   = alu_q;
    assign Direccion_out    = dir_q;
    assign jump_address_out = jump_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: three instances (1, 3 and 0 wait cycles) driven by
// scenario tasks and checked against a word-array model of data memory.
module tb_memory_access;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [3];
    logic [2:0]  m_s     [3];
    logic [2:0]  wb_s    [3];
    logic [31:0] alu_s   [3];
    logic [31:0] add_s   [3];
    logic        zero_s  [3];
    logic [31:0] data_s  [3];
    logic [4:0]  dir_s   [3];
    logic [31:0] jmp_s   [3];
    logic        stall_s [3];
    logic        pcsrc_s [3];
    logic [31:0] bt_s    [3];
    logic [2:0]  wbo_s   [3];
    logic [31:0] rdo_s   [3];
    logic [31:0] aluo_s  [3];
    logic [4:0]  diro_s  [3];
    logic [31:0] jmpo_s  [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        memory_access #(
            .MEM_WORDS  (256),
            .ADDR_BITS  (8),
            .WAIT_CYCLES((gi == 0) ? 1 : (gi == 1) ? 3 : 0)
        ) dut (
            .clk             (clk),
            .rst             (rst_s[gi]),
            .M               (m_s[gi]),
            .WB              (wb_s[gi]),
            .Alu_result      (alu_s[gi]),
            .Add_result      (add_s[gi]),
            .Zero            (zero_s[gi]),
            .Dato2_M         (data_s[gi]),
            .Direccion       (dir_s[gi]),
            .jump_address    (jmp_s[gi]),
            .stall           (stall_s[gi]),
            .PCSrc           (pcsrc_s[gi]),
            .Branch_target   (bt_s[gi]),
            .WB_out          (wbo_s[gi]),
            .Read_data_out   (rdo_s[gi]),
            .Alu_result_out  (aluo_s[gi]),
            .Direccion_out   (diro_s[gi]),
            .jump_address_out(jmpo_s[gi])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model memory per instance; valid marks words whose contents are known
    logic [31:0] model_mem   [3][256];
    bit          model_valid [3][256];

    function automatic int wait_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % 256);
    endfunction

    task automatic check_memwb(input int d, input string name, input logic [2:0] wb,
                               input logic [31:0] rd, input logic [31:0] alu,
                               input logic [4:0] dir, input logic [31:0] jmp, input bit check_rd);
        n_checks++;
        if (wbo_s[d] !== wb || aluo_s[d] !== alu || diro_s[d] !== dir || jmpo_s[d] !== jmp ||
            (check_rd && rdo_s[d] !== rd)) begin
            $display("FAIL %s dut%0d: got wb=%b rd=%h alu=%h dir=%0d jmp=%h, want wb=%b rd=%h alu=%h dir=%0d jmp=%h",
                     name, d, wbo_s[d], rdo_s[d], aluo_s[d], diro_s[d], jmpo_s[d], wb, rd, alu, dir, jmp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs one instruction through the stage; entered and left at a negedge
    task automatic do_op(input int d, input string name, input logic [2:0] m, input logic [2:0] wb,
                         input logic [31:0] alu, input logic [31:0] add, input logic zero,
                         input logic [31:0] data, input logic [4:0] dir, input logic [31:0] jmp);
        int  wc     = wait_of(d);
        bit  memop  = m[1] | m[0];
        int  cycles = memop ? wc + 1 : 1;
        int  idx    = word_of(alu);
        bit  exp_stall;
        logic [31:0] exp_rd;
        bit  rd_known;
        m_s[d] = m; wb_s[d] = wb; alu_s[d] = alu; add_s[d] = add; zero_s[d] = zero;
        data_s[d] = data; dir_s[d] = dir; jmp_s[d] = jmp;
        for (int k = 0; k < cycles; k++) begin
            #1;
            exp_stall = memop && (k < wc);
            n_checks++;
            if (stall_s[d] !== exp_stall)
                $display("FAIL %s_stall dut%0d cyc%0d: got %b want %b", name, d, k, stall_s[d], exp_stall);
            else n_pass++;
            n_checks++;
            if (pcsrc_s[d] !== (m[2] & zero & ~exp_stall) || bt_s[d] !== add)
                $display("FAIL %s_branch dut%0d cyc%0d: got pcsrc=%b bt=%h want pcsrc=%b bt=%h",
                         name, d, k, pcsrc_s[d], bt_s[d], m[2] & zero & ~exp_stall, add);
            else n_pass++;
            @(posedge clk);
            #1;
            if (exp_stall) begin
                check_memwb(d, {name, "_bubble"}, 3'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
            end else begin
                rd_known = !m[1] || model_valid[d][idx];
                exp_rd   = m[1] ? model_mem[d][idx] : 32'd0;
                check_memwb(d, name, wb, exp_rd, alu, dir, jmp, rd_known);
                $display("op %s dut%0d m=%b addr=%h data=%h rd=%h", name, d, m, alu, data, rdo_s[d]);
                if (m[0]) begin
                    model_mem[d][idx]   = data;
                    model_valid[d][idx] = 1'b1;
                end
            end
            @(negedge clk);
        end
        m_s[d] = 3'b000;
    endtask

    task automatic test_reset(input int d);
        rst_s[d] = 1'b1; m_s[d] = 3'b100; zero_s[d] = 1'b1; add_s[d] = 32'h0000_1234;
        @(posedge clk);
        #1;
        check_memwb(d, "reset", 3'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        n_checks++;
        if (stall_s[d] !== 1'b0 || pcsrc_s[d] !== 1'b1 || bt_s[d] !== 32'h0000_1234)
            $display("FAIL reset_comb dut%0d: got stall=%b pcsrc=%b bt=%h want 0 1 00001234",
                     d, stall_s[d], pcsrc_s[d], bt_s[d]);
        else n_pass++;
        @(negedge clk);
        rst_s[d] = 1'b0; m_s[d] = 3'b000; zero_s[d] = 1'b0;
    endtask

    task automatic test_store_load;
        do_op(0, "st10", 3'b001, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 5'd4, 32'h100);
        do_op(0, "ld10", 3'b010, 3'b011, 32'h10, 32'h0, 1'b0, 32'h0, 5'd5, 32'h104);
    endtask

    task automatic test_wrap;
        do_op(0, "st403", 3'b001, 3'b000, 32'h403, 32'h0, 1'b0, 32'h12345678, 5'd0, 32'h0);
        do_op(0, "ld003", 3'b010, 3'b001, 32'h003, 32'h0, 1'b0, 32'h0, 5'd7, 32'h0);
        n_checks++;
        if (rdo_s[0] !== 32'h12345678)
            $display("FAIL wrap_data: got %h want 12345678", rdo_s[0]);
        else n_pass++;
    endtask

    task automatic test_nonmem;
        do_op(0, "alu", 3'b000, 3'b101, 32'h55, 32'h8, 1'b1, 32'hFFFF, 5'd9, 32'h200);
    endtask

    task automatic test_branch;
        do_op(0, "br_taken", 3'b100, 3'b000, 32'h0, 32'h40, 1'b1, 32'h0, 5'd0, 32'h0);
        do_op(0, "br_not", 3'b100, 3'b000, 32'h0, 32'h40, 1'b0, 32'h0, 5'd0, 32'h0);
    endtask

    task automatic test_both_rw;
        do_op(0, "st_pre", 3'b001, 3'b000, 32'h80, 32'h0, 1'b0, 32'hAAAA5555, 5'd0, 32'h0);
        do_op(0, "rw", 3'b011, 3'b001, 32'h80, 32'h0, 1'b0, 32'h0BADF00D, 5'd1, 32'h0);
        do_op(0, "ld_post", 3'b010, 3'b001, 32'h80, 32'h0, 1'b0, 32'h0, 5'd2, 32'h0);
    endtask

    task automatic test_reset_mid_access;
        do_op(1, "st20", 3'b001, 3'b000, 32'h20, 32'h0, 1'b0, 32'h11112222, 5'd0, 32'h0);
        m_s[1] = 3'b001; alu_s[1] = 32'h20; data_s[1] = 32'h99998888;
        wb_s[1] = 3'b111; dir_s[1] = 5'd3;
        @(posedge clk);
        @(negedge clk);
        rst_s[1] = 1'b1;
        @(posedge clk);
        #1;
        m_s[1] = 3'b000;
        #1;
        n_checks++;
        if (stall_s[1] !== 1'b0)
            $display("FAIL rst_mid_stall: got %b want 0", stall_s[1]);
        else n_pass++;
        check_memwb(1, "rst_mid_out", 3'b0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        $display("op rst_mid dut1 abandoned store addr=00000020 data=99998888");
        @(negedge clk);
        rst_s[1] = 1'b0;
        do_op(1, "ld20", 3'b010, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0, 5'd6, 32'h0);
        n_checks++;
        if (rdo_s[1] !== 32'h11112222)
            $display("FAIL rst_mid_data: got %h want 11112222", rdo_s[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a = {$urandom_range(0, 1023), 2'b00};
            logic [31:0] v = $urandom;
            do_op(2, "b2b_st", 3'b001, 3'($urandom), a, $urandom, 1'b0, v, 5'($urandom), $urandom);
            do_op(2, "b2b_ld", 3'b010, 3'($urandom), a, $urandom, 1'b0, 32'h0, 5'($urandom), $urandom);
        end
    endtask

    task automatic test_random(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            do_op(d, "rnd", 3'($urandom), 3'($urandom), {22'($urandom), 4'($urandom), 6'($urandom)},
                  $urandom, 1'($urandom), $urandom, 5'($urandom), $urandom);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_s[d] = 1'b1; m_s[d] = '0; wb_s[d] = '0; alu_s[d] = '0; add_s[d] = '0;
            zero_s[d] = 1'b0; data_s[d] = '0; dir_s[d] = '0; jmp_s[d] = '0;
            for (int w = 0; w < 256; w++) begin
                model_mem[d][w]   = '0;
                model_valid[d][w] = 1'b0;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) test_reset(d);
        test_store_load();
        test_wrap();
        test_nonmem();
        test_branch();
        test_both_rw();
        test_reset_mid_access();
        test_back_to_back();
        for (int d = 0; d < 3; d++) test_random(d, 40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS-32 pipeline, directly downstream of the execute stage.
- Consumes the EX/MEM register contents: ALU result, branch target, Zero flag, store data, destination register, M/WB control and jump address.
- Performs data-memory load/store with a configurable wait-state handshake (stall) and resolves branches.
- Registers results into the MEM/WB pipeline register for write-back.

Parameters:
- MEM_WORDS, 256, data memory depth in 32-bit words (power of 2).
- ADDR_BITS, 8, log2(MEM_WORDS); word index = Alu_result[ADDR_BITS+1:2].
- WAIT_CYCLES, 1, stall cycles per load/store (0 = single-cycle memory).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- M  in  3  memory control: [2]=Branch, [1]=MemRead, [0]=MemWrite.
- WB  in  3  write-back control, passed through opaque.
- Alu_result  in  32  memory byte address / ALU value.
- Add_result  in  32  branch target.
- Zero  in  1  ALU zero flag.
- Dato2_M  in  32  store data.
- Direccion  in  5  destination register.
- jump_address  in  32  jump target, passed through.
- stall  out  1  hold upstream stages and PC this cycle.
- PCSrc  out  1  take branch.
- Branch_target  out  32  = Add_result.
- WB_out  out  3  MEM/WB register.
- Read_data_out  out  32  MEM/WB register: load data.
- Alu_result_out  out  32  MEM/WB register.
- Direccion_out  out  5  MEM/WB register.
- jump_address_out  out  32  MEM/WB register.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - On rst, all MEM/WB outputs go to 0 and the FSM goes to IDLE with cnt=0.
  - Memory contents are not cleared.
- mem_op = M[1] | M[0].
- FSM states IDLE, WAIT; down-counter cnt, width sufficient for WAIT_CYCLES.
- IDLE, !mem_op: stall=0. MEM/WB captures the inputs at the edge, with Read_data_out=0.
- IDLE, mem_op, WAIT_CYCLES=0: access completes this cycle, stall=0. Write commits at the edge; read data is captured at the edge.
- IDLE, mem_op, WAIT_CYCLES>0: stall=1, cnt<=WAIT_CYCLES-1, state<=WAIT.
  - MEM/WB loads a bubble: all fields 0.
- WAIT, cnt!=0: stall=1, cnt<=cnt-1, MEM/WB loads a bubble.
- WAIT, cnt==0: stall=0. Access completes: write commits, MEM/WB captures inputs plus read data, state<=IDLE.
- Timing summary:
  - A load/store occupies WAIT_CYCLES+1 cycles.
  - stall is high for exactly WAIT_CYCLES of them.
  - Back-to-back memory ops each pay the full wait.
- Upstream holds all inputs stable while stall=1. The block samples inputs only at completion.
- stall is combinational from state, cnt and M.
- Memory write happens exactly once per store, on the completion edge. No partial or duplicate writes.
- Address: word index Alu_result[ADDR_BITS+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so the address wraps modulo MEM_WORDS words.
- Load data: Read_data_out = mem[index] as held before the completion edge.
- MemRead and MemWrite both set: the write is performed and Read_data_out returns the pre-write contents.
- Branch resolution: PCSrc = M[2] & Zero, combinational; Branch_target = Add_result.
  - PCSrc is forced to 0 while stall=1.
  - rst forces nothing on PCSrc/Branch_target, which remain combinational.
- Reset mid-access: a pending store in WAIT is abandoned, with no memory write. stall=0 from the cycle after reset (FSM in IDLE).

Test Plan:
- WAIT_CYCLES=1: store Dato2_M=0xDEADBEEF to Alu_result=0x10, then load 0x10 -> each op has stall=1 for one cycle. Store has WB_out=0 bubble then a capture. Load gives Read_data_out=0xDEADBEEF on its completion edge.
- Wrap/alignment: store 0x12345678 to address 0x403, load from 0x003 -> Read_data_out=0x12345678 (index 0, MEM_WORDS=256).
- Non-memory op, M=3'b000, WB=3'b101, Alu_result=0x55, Direccion=9 -> no stall. Next edge: WB_out=101, Alu_result_out=0x55, Direccion_out=9, Read_data_out=0.
- Branch: M=3'b100, Zero=1, Add_result=0x40 -> PCSrc=1, Branch_target=0x40. With Zero=0 -> PCSrc=0.
- WAIT_CYCLES=3: store to 0x20 with rst pulsed on the second stall cycle, then load 0x20 -> old contents returned (no write). stall=0 the cycle after rst; outputs 0 after rst.
- WAIT_CYCLES=0: alternating store/load every cycle -> stall never asserts; loads return the data just stored.
